read_bitstring: RTL and testbench
=================================

// Module: read_bitstring
// PURPOSE
//  JPEG entropy-segment bit reader; inverse of the bitstring writer. Takes an entropy-coded byte stream,
//  removes 0xFF00 stuffing, detects markers, and serves variable-length bit fields MSB-first on request.
//  Sits between the byte source and the Huffman/coefficient decoder in the JPEG decode path.
// PARAMETERS
//  ACC_W   32   bit accumulator width; must be >= 24 so that a 15-bit request fits beside a fresh byte
// PORTS
//  clk            in   1   single clock, all logic rising-edge
//  rst            in   1   synchronous, active-high reset
//  flush          in   1   sync clear of accumulator/FSMs/flags; same effect as rst except port outputs hold
//  s_axis_tdata   in   8   entropy-coded byte
//  s_axis_tvalid  in   1   byte valid
//  s_axis_tuser   in   1   first byte of scan
//  s_axis_tlast   in   1   last byte of scan
//  s_axis_tready  out  1   byte accepted when tvalid&&tready
//  req_valid      in   1   bit-field request
//  req_len        in   4   requested bits, 0..15
//  req_ready      out  1   request accepted when req_valid&&req_ready
//  m_axis_tdata   out  32  {12'd0, length[3:0], value[15:0]}; value right-aligned, zero-extended
//  m_axis_tvalid  out  1   response valid
//  m_axis_tuser   out  1   first response after a tuser byte was accepted
//  m_axis_tlast   out  1   input ended and <8 bits remain after this response
//  m_axis_tready  in   1   response taken
//  marker_valid   out  1   1-cycle pulse: marker found (0xFF + non-00, non-FF byte)
//  marker_code    out  8   marker second byte; holds until next marker
//  underrun       out  1   sticky: a request was padded past end of data
// BEHAVIOUR
//  Reset: all outputs 0; acc=0, acc_cnt=0, input FSM S_DATA, output FSM O_IDLE.
//  Input FSM (unstuffer): s_axis_tready = (acc_cnt <= ACC_W-8) && state!=S_HALT && !in_done.
//   S_DATA: byte!=FF -> append; byte==FF -> S_FF (nothing appended).
//   S_FF: 00 -> append FF, S_DATA; FF -> fill byte, discard, stay S_FF;
//    other X -> marker_valid=1, marker_code=X, S_HALT.
//   S_HALT: no bytes accepted until rst/flush. in_done set by accepted tlast byte or by entering S_HALT.
//   Byte with tuser: sets pending_first; next response carries m_axis_tuser=1, then pending_first clears.
//   tlast while in S_FF: the dangling FF is dropped.
//  Accumulator: MSB-aligned, acc_cnt 0..ACC_W. Append places byte at bits [ACC_W-1-acc_cnt -: 8].
//   Same-cycle consume L and append: acc_next = (acc<<L) | (byte << (ACC_W-8-(acc_cnt-L)));
//   acc_cnt_next = acc_cnt - L + 8. Never overflows because of the tready rule.
//  Output FSM:
//   O_IDLE: req_ready=1; accept -> latch L, O_WAIT.
//   O_WAIT: if acc_cnt>=L: value=acc[ACC_W-1 -: L], consume L, register response, O_RESP.
//    elif in_done: missing low bits filled with 1s, acc_cnt->0, underrun<=1, register, O_RESP.
//   O_RESP: m_axis_tvalid=1, tdata/tuser/tlast stable until m_axis_tready; then O_IDLE.
//  L=0: value 0, length 0, no consume; takes the O_WAIT path normally.
//  Latency: tvalid no earlier than 2 cycles after the req handshake; one request in flight.
//  rst/flush mid-operation: any response in flight is dropped, no handshake completion needed.
//  Width rules: value zero-extended to 16; length echoes req_len; all shifts are logical.
// STRUCTURE
//  Package jpeg_bitstream_pkg: BitString typedef {value[15:0], length[3:0]} shared with writer;
//   constants MARKER_PREFIX=8'hFF, STUFF=8'h00, EOI=8'hD9, RST0..RST7=8'hD0..D7.
//  Sub-module byte_unstuffer: input FSM, outputs {byte, byte_valid, marker_*, in_done}.
//   read_bitstring holds the accumulator and output FSM.
// TESTING
//  1 bytes A5 3C; req 4,4,8 -> values 0xA, 0x5, 0x3C; tuser=1 on first response only.
//  2 bytes FF 00 12; req 8,8 -> 0xFF, 0x12; marker_valid stays 0.
//  3 bytes 12 FF D9; req 8 -> 0x12; marker_valid pulse with code D9; tready then 0.
//    req 4 -> 0xF, underrun=1.
//  4 bytes 81 FF 00; req 15 -> 0x40FF; req 1 -> 0x1 with m_axis_tlast=1 (tlast on last byte).
//  5 bytes FF FF 00 (fill byte) -> single data FF; req 0 -> length 0, value 0, no bits consumed.
//  6 m_axis_tready low for 5 cycles -> tdata stable, no loss; assert rst during O_WAIT ->
//    all outputs 0 next cycle; then reuse stream 1 with identical results.

Source files
------------

// File: rtl/jpeg_bitstream_pkg.sv
// jpeg_bitstream_pkg: shared JPEG bitstream types, FSM states and marker constants
package jpeg_bitstream_pkg;
  typedef struct packed {
    logic [3:0]  length;
    logic [15:0] value;
  } bitstring_t;
  typedef enum logic [1:0] {S_DATA, S_FF, S_HALT} in_state_t;
  typedef enum logic [1:0] {O_IDLE, O_WAIT, O_RESP} out_state_t;
  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF = 8'h00;
  localparam logic [7:0] EOI = 8'hD9;
  localparam logic [7:0] RST0 = 8'hD0;
  localparam logic [7:0] RST7 = 8'hD7;
endpackage

// File: rtl/byte_unstuffer.sv
// byte_unstuffer: removes FF00 stuffing, drops fill bytes, detects markers
//  in:  clk, rst, flush, i_space (accumulator can take a byte), s_axis_* byte stream
//  out: s_axis_tready, o_byte/o_byte_valid (data byte to append), o_first (tuser byte accepted),
//       marker_valid/marker_code, o_in_done (no more bytes will arrive)
module byte_unstuffer
  import jpeg_bitstream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       i_space,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tuser,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_first,
  output logic       marker_valid,
  output logic [7:0] marker_code,
  output logic       o_in_done
);
  in_state_t  r_state, w_state_next;
  logic       r_in_done, r_marker_valid, w_acc, w_marker;
  logic [7:0] r_marker_code;
  always_comb begin
    s_axis_tready = i_space && r_state != S_HALT && !r_in_done;
    w_acc = s_axis_tvalid && s_axis_tready;
    o_first = w_acc && s_axis_tuser;
    o_byte = r_state == S_FF ? MARKER_PREFIX : s_axis_tdata;
    o_byte_valid = w_acc && (r_state == S_DATA ? s_axis_tdata != MARKER_PREFIX : s_axis_tdata == STUFF);
    w_marker = w_acc && r_state == S_FF && s_axis_tdata != STUFF && s_axis_tdata != MARKER_PREFIX;
    w_state_next = !w_acc ? r_state :
                   r_state == S_DATA ? (s_axis_tdata == MARKER_PREFIX ? S_FF : S_DATA) :
                   s_axis_tdata == STUFF ? S_DATA : w_marker ? S_HALT : S_FF;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_DATA;
      r_in_done <= 1'b0;
      r_marker_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_in_done <= r_in_done || (w_acc && s_axis_tlast) || w_marker;
      r_marker_valid <= w_marker;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_marker_code <= 8'd0;
    else if (w_marker && !flush) r_marker_code <= s_axis_tdata;
  end
  assign marker_valid = r_marker_valid;
  assign marker_code = r_marker_code;
  assign o_in_done = r_in_done;
endmodule

// File: rtl/read_bitstring.sv
// read_bitstring: JPEG entropy bit reader serving MSB-first bit fields from an unstuffed byte stream
//  in:  clk, rst, flush, s_axis_* entropy bytes, req_valid/req_len bit-field requests, m_axis_tready
//  out: s_axis_tready, req_ready, m_axis_* responses {12'd0, len, value}, marker_valid/marker_code,
//       underrun (sticky: a response was padded with 1s past end of data)
module read_bitstring
  import jpeg_bitstream_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic        req_valid,
  input  logic [3:0]  req_len,
  output logic        req_ready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        marker_valid,
  output logic [7:0]  marker_code,
  output logic        underrun
);
  localparam int CW = $clog2(ACC_W + 1);
  logic [ACC_W-1:0] r_acc, w_acc_next, w_acc_shift;
  logic [CW-1:0]    r_cnt, w_cnt_after, w_cnt_next;
  out_state_t       r_state, w_state_next;
  logic [3:0]       r_len, w_shift;
  logic [15:0]      w_top, w_fill, w_val;
  logic [31:0]      r_tdata;
  logic [7:0]       w_byte;
  logic             w_take, w_pad, w_resp, w_space, w_byte_valid, w_first, w_in_done;
  logic             r_pending, r_underrun, r_tuser, r_tlast;
  bitstring_t       w_bits;
  byte_unstuffer u_unstuffer (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .i_space      (w_space),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_first      (w_first),
    .marker_valid (marker_valid),
    .marker_code  (marker_code),
    .o_in_done    (w_in_done)
  );
  always_comb begin
    w_space = r_cnt <= CW'(ACC_W - 8);
    w_top = r_acc[ACC_W-1 -: 16];
    // ones below the valid bits stand in for data that will never arrive
    w_fill = 16'hFFFF >> r_cnt;
    w_take = r_state == O_WAIT && r_cnt >= CW'(r_len);
    w_pad = r_state == O_WAIT && !w_take && w_in_done;
    w_resp = w_take || w_pad;
    w_val = (w_take ? w_top : w_top | w_fill) >> (5'd16 - 5'(r_len));
    w_bits = '{length: r_len, value: w_val};
    w_shift = w_take ? r_len : 4'd0;
    w_cnt_after = w_pad ? '0 : r_cnt - CW'(w_shift);
    w_acc_shift = w_pad ? '0 : r_acc << w_shift;
    // the incoming byte lands just below the bits that survive this cycle's consume
    w_acc_next = w_acc_shift | (w_byte_valid ? ({w_byte, {(ACC_W-8){1'b0}}} >> w_cnt_after) : '0);
    w_cnt_next = w_cnt_after + (w_byte_valid ? CW'(8) : '0);
    w_state_next = r_state == O_IDLE ? (req_valid ? O_WAIT : O_IDLE) :
                   r_state == O_WAIT ? (w_resp ? O_RESP : O_WAIT) :
                   m_axis_tready ? O_IDLE : O_RESP;
    req_ready = r_state == O_IDLE;
    m_axis_tvalid = r_state == O_RESP;
    m_axis_tdata = r_tdata;
    m_axis_tuser = r_tuser;
    m_axis_tlast = r_tlast;
    underrun = r_underrun;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= O_IDLE;
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= 4'd0;
      r_pending <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      if (req_valid && req_ready) r_len <= req_len;
      r_pending <= w_first || (r_pending && !w_resp);
      r_underrun <= r_underrun || w_pad;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata <= 32'd0;
      r_tuser <= 1'b0;
      r_tlast <= 1'b0;
    end else if (w_resp && !flush) begin
      r_tdata <= {12'd0, w_bits};
      r_tuser <= r_pending;
      r_tlast <= w_in_done && w_cnt_after < CW'(8);
    end
  end
endmodule

// File: tb/tb_read_bitstring.sv
// tb_read_bitstring: scoreboard bench for the JPEG bit reader
module tb_read_bitstring;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic        req_valid = 1'b0, req_ready, m_axis_tready = 1'b0;
  logic [3:0]  req_len = 4'd0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, marker_valid, underrun;
  logic [7:0]  marker_code;
  int passed = 0, total = 0, mk_seen = 0;
  logic [7:0] mk_code = 8'd0;
  typedef struct packed {logic [31:0] d; logic u; logic l;} exp_t;
  exp_t sb[$];

  read_bitstring dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .marker_valid(marker_valid), .marker_code(marker_code), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (marker_valid) begin mk_seen++; mk_code = marker_code; end

  task automatic do_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    mk_seen = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic u, input logic l);
    int n = 0;
    s_axis_tdata = b; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      total++;
      $display("FAIL send_byte timeout: tready=%b after %0d cycles, want 1", s_axis_tready, n);
    end else begin
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic req_resp(input logic [3:0] len, input int stall, output logic [31:0] d,
                          output logic u, output logic l, output int lat, output bit st);
    int n = 0;
    req_valid = 1'b1; req_len = len;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 1;
    while (!m_axis_tvalid && lat < 50) begin @(posedge clk); #1; lat++; end
    d = m_axis_tdata; u = m_axis_tuser; l = m_axis_tlast; st = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
      if (m_axis_tdata !== d || m_axis_tvalid !== 1'b1 || m_axis_tuser !== u || m_axis_tlast !== l) st = 1'b0;
    end
    m_axis_tready = 1'b1;
    @(posedge clk); #1 m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, marker_valid, marker_code, underrun} !== 44'd0)
      $display("FAIL reset_outputs: got tv=%b td=%h tu=%b tl=%b mv=%b mc=%h ur=%b, want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, marker_valid, marker_code, underrun);
    else passed++;
    total++;
    if ({s_axis_tready, req_ready} !== 2'b11)
      $display("FAIL reset_ready: got s_tready=%b req_ready=%b, want 1 1", s_axis_tready, req_ready);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic(input string tag);
    logic [3:0] lens [3] = '{4'd4, 4'd4, 4'd8};
    exp_t exps [3] = '{'{32'h0004000A, 1'b1, 1'b0}, '{32'h00040005, 1'b0, 1'b0}, '{32'h0008003C, 1'b0, 1'b0}};
    logic [31:0] d; logic u, l; int lat; bit st; exp_t e;
    do_flush();
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exps[i]);
      req_resp(lens[i], 0, d, u, l, lat, st);
      e = sb.pop_front();
      total++;
      if ({d, u, l} !== {e.d, e.u, e.l})
        $display("FAIL %s resp%0d: got d=%h u=%b l=%b, want d=%h u=%b l=%b", tag, i, d, u, l, e.d, e.u, e.l);
      else passed++;
      total++;
      if (lat < 2 || lat >= 50) $display("FAIL %s latency%0d: got %0d cycles, want 2..49", tag, i, lat);
      else passed++;
    end
  endtask

  task automatic test_stuffing();
    logic [3:0] lens [2] = '{4'd8, 4'd8};
    exp_t exps [2] = '{'{32'h000800FF, 1'b0, 1'b0}, '{32'h00080012, 1'b0, 1'b0}};
    logic [31:0] d; logic u, l; int lat; bit st; exp_t e;
    do_flush();
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exps[i]);
      req_resp(lens[i], 0, d, u, l, lat, st);
      e = sb.pop_front();
      total++;
      if ({d, u, l} !== {e.d, e.u, e.l})
        $display("FAIL stuffing resp%0d: got d=%h u=%b l=%b, want d=%h u=%b l=%b", i, d, u, l, e.d, e.u, e.l);
      else passed++;
    end
    total++;
    if (mk_seen !== 0) $display("FAIL stuffing marker: got %0d pulses, want 0", mk_seen);
    else passed++;
  endtask

  task automatic test_marker_underrun();
    logic [31:0] d; logic u, l; int lat; bit st; exp_t e;
    do_flush();
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'hD9, 1'b0, 1'b0);
    total++;
    if (s_axis_tready !== 1'b0) $display("FAIL marker_halt_tready: got %b, want 0", s_axis_tready);
    else passed++;
    sb.push_back('{32'h00080012, 1'b0, 1'b1});
    req_resp(4'd8, 0, d, u, l, lat, st);
    e = sb.pop_front();
    total++;
    if ({d, u, l} !== {e.d, e.u, e.l})
      $display("FAIL marker resp0: got d=%h u=%b l=%b, want d=%h u=%b l=%b", d, u, l, e.d, e.u, e.l);
    else passed++;
    total++;
    if (underrun !== 1'b0) $display("FAIL underrun_early: got %b, want 0", underrun);
    else passed++;
    sb.push_back('{32'h0004000F, 1'b0, 1'b1});
    req_resp(4'd4, 0, d, u, l, lat, st);
    e = sb.pop_front();
    total++;
    if ({d, u, l} !== {e.d, e.u, e.l})
      $display("FAIL underrun resp: got d=%h u=%b l=%b, want d=%h u=%b l=%b", d, u, l, e.d, e.u, e.l);
    else passed++;
    total++;
    if (underrun !== 1'b1) $display("FAIL underrun_flag: got %b, want 1", underrun);
    else passed++;
    total++;
    if (mk_seen !== 1 || mk_code !== 8'hD9 || marker_code !== 8'hD9)
      $display("FAIL marker_pulse: got pulses=%0d code=%h hold=%h, want 1 d9 d9", mk_seen, mk_code, marker_code);
    else passed++;
  endtask

  task automatic test_long_tlast();
    logic [3:0] lens [2] = '{4'd15, 4'd1};
    exp_t exps [2] = '{'{32'h000F40FF, 1'b0, 1'b1}, '{32'h00010001, 1'b0, 1'b1}};
    logic [31:0] d; logic u, l; int lat; bit st; exp_t e;
    do_flush();
    total++;
    if (underrun !== 1'b0) $display("FAIL flush_underrun: got %b, want 0", underrun);
    else passed++;
    send_byte(8'h81, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exps[i]);
      req_resp(lens[i], 0, d, u, l, lat, st);
      e = sb.pop_front();
      total++;
      if ({d, u, l} !== {e.d, e.u, e.l})
        $display("FAIL long_tlast resp%0d: got d=%h u=%b l=%b, want d=%h u=%b l=%b", i, d, u, l, e.d, e.u, e.l);
      else passed++;
    end
  endtask

  task automatic test_fill_zero_len();
    logic [3:0] lens [2] = '{4'd0, 4'd8};
    exp_t exps [2] = '{'{32'h00000000, 1'b0, 1'b0}, '{32'h000800FF, 1'b0, 1'b0}};
    logic [31:0] d; logic u, l; int lat; bit st; exp_t e;
    do_flush();
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(exps[i]);
      req_resp(lens[i], 0, d, u, l, lat, st);
      e = sb.pop_front();
      total++;
      if ({d, u, l} !== {e.d, e.u, e.l})
        $display("FAIL fill_zero resp%0d: got d=%h u=%b l=%b, want d=%h u=%b l=%b", i, d, u, l, e.d, e.u, e.l);
      else passed++;
    end
  endtask

  task automatic test_stall_reset();
    logic [31:0] d; logic u, l; int lat; bit st; exp_t e;
    do_flush();
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    sb.push_back('{32'h0004000A, 1'b1, 1'b0});
    req_resp(4'd4, 5, d, u, l, lat, st);
    e = sb.pop_front();
    total++;
    if ({d, u, l} !== {e.d, e.u, e.l})
      $display("FAIL stall resp: got d=%h u=%b l=%b, want d=%h u=%b l=%b", d, u, l, e.d, e.u, e.l);
    else passed++;
    total++;
    if (st !== 1'b1) $display("FAIL stall_stable: got stable=%b, want 1", st);
    else passed++;
    req_valid = 1'b1; req_len = 4'd15;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL wait_stuck: got tvalid=%b, want 0", m_axis_tvalid);
    else passed++;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, marker_valid, marker_code, underrun} !== 44'd0)
      $display("FAIL midreset_outputs: got tv=%b td=%h tu=%b tl=%b mv=%b mc=%h ur=%b, want all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, marker_valid, marker_code, underrun);
    else passed++;
    test_basic("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_stuffing();
    test_marker_underrun();
    test_long_tlast();
    test_fill_zero_len();
    test_stall_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
